// File: rtl/axis_chunker.sv
// rtl/axis_chunker.sv - AXI-Stream packetiser closing packets on source TLAST, length cap or idle timeout
// One beat is held in P so TLAST can be decided after the fact; O drives m_* straight from registers.
module axis_chunker #(
  parameter int WIDTH   = 8,
  parameter int MAXLEN  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [WIDTH-1:0] m_tdata,
  output logic             tout_o
);
  localparam int CW = $clog2(MAXLEN + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(MAXLEN - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  logic             p_valid_q, p_valid_d;
  logic [WIDTH-1:0] p_data_q, p_data_d;
  logic             p_fin_q, p_fin_d;
  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_data_q, o_data_d;
  logic             o_last_q, o_last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idle_q, idle_d;

  logic o_free, acc, move, fin, tmr_run, tmr_hit;

  assign o_free   = !o_valid_q || m_tready;
  assign acc      = s_tvalid && o_free;
  // A non-final held beat only leaves once its successor proves it is not the last.
  assign move     = o_free && p_valid_q && (p_fin_q || acc);
  assign fin      = s_tlast || (cnt_q == CNT_LAST);
  assign tmr_run  = (TIMEOUT != 0) && p_valid_q && !p_fin_q && !acc;
  assign tmr_hit  = tmr_run && (idle_q == IDLE_LAST);

  assign s_tready = o_free;
  assign m_tvalid = o_valid_q;
  assign m_tdata  = o_data_q;
  assign m_tlast  = o_last_q;
  assign tout_o   = tmr_hit;

  always_comb begin
    p_valid_d = p_valid_q;
    p_data_d  = p_data_q;
    p_fin_d   = p_fin_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;

    if (move) begin
      o_valid_d = 1'b1;
      o_data_d  = p_data_q;
      o_last_d  = p_fin_q;
    end else if (m_tready) begin
      o_valid_d = 1'b0;
    end

    if (acc) begin
      p_valid_d = 1'b1;
      p_data_d  = s_tdata;
      p_fin_d   = fin;
      cnt_d     = fin ? '0 : cnt_q + CW'(1);
      idle_d    = '0;
    end else begin
      if (move) begin
        p_valid_d = 1'b0;
      end
      if (tmr_hit) begin
        p_fin_d = 1'b1;
        cnt_d   = '0;
        idle_d  = '0;
      end else if (tmr_run) begin
        idle_d = idle_q + IW'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      p_valid_q <= 1'b0;
      p_data_q  <= '0;
      p_fin_q   <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      cnt_q     <= '0;
      idle_q    <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      p_data_q  <= p_data_d;
      p_fin_q   <= p_fin_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
    end
  end
endmodule

// File: tb/tb_axis_chunker.sv
// tb/tb_axis_chunker.sv - scoreboard bench for axis_chunker (MAXLEN=4; TIMEOUT=8 on u_a, TIMEOUT=0 on u_b)
module tb_axis_chunker;
  typedef struct {
    logic [7:0] d;
    logic       l;
    int         c;
  } exp_t;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       a_s_tvalid = 1'b0, a_s_tlast = 1'b0, a_m_tready = 1'b1;
  logic [7:0] a_s_tdata = '0;
  logic       a_s_tready, a_m_tvalid, a_m_tlast, a_tout;
  logic [7:0] a_m_tdata;
  logic       b_s_tvalid = 1'b0, b_s_tlast = 1'b0, b_m_tready = 1'b1;
  logic [7:0] b_s_tdata = '0;
  logic       b_s_tready, b_m_tvalid, b_m_tlast, b_tout;
  logic [7:0] b_m_tdata;

  int   cyc = 0, n_cmp = 0, n_err = 0;
  int   a_tout_n = 0, a_tout_cyc = -1, b_tout_n = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;

  axis_chunker #(.WIDTH(8), .MAXLEN(4), .TIMEOUT(8)) u_a (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(a_s_tvalid), .s_tready(a_s_tready), .s_tlast(a_s_tlast), .s_tdata(a_s_tdata),
    .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tlast(a_m_tlast), .m_tdata(a_m_tdata),
    .tout_o(a_tout)
  );

  axis_chunker #(.WIDTH(8), .MAXLEN(4), .TIMEOUT(0)) u_b (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tlast(b_s_tlast), .s_tdata(b_s_tdata),
    .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tlast(b_m_tlast), .m_tdata(b_m_tdata),
    .tout_o(b_tout)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic push_a(input logic [7:0] d, input logic l, input int c);
    exp_t e;
    e.d = d; e.l = l; e.c = c;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] d, input logic l, input int c);
    exp_t e;
    e.d = d; e.l = l; e.c = c;
    qb.push_back(e);
  endtask

  // Output-side monitors: pop on every handshake, compare data, TLAST and cycle.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (a_m_tvalid && a_m_tready) begin
        if (qa.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL a_unexpected: got data %0h last %0b want no beat (cyc %0d)", a_m_tdata, a_m_tlast, cyc);
        end else begin
          ea = qa.pop_front();
          chk("a_data", a_m_tdata, ea.d);
          chk("a_last", a_m_tlast, ea.l);
          if (ea.c >= 0) chk("a_out_cyc", cyc, ea.c);
        end
      end
      if (a_m_tvalid && !a_m_tready) chk("a_stall_s_tready", a_s_tready, 0);
      if (a_tout) begin a_tout_n++; a_tout_cyc = cyc; end
    end
  end

  always @(negedge aclk) begin
    if (aresetn) begin
      if (b_m_tvalid && b_m_tready) begin
        if (qb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b_unexpected: got data %0h last %0b want no beat (cyc %0d)", b_m_tdata, b_m_tlast, cyc);
        end else begin
          eb = qb.pop_front();
          chk("b_data", b_m_tdata, eb.d);
          chk("b_last", b_m_tlast, eb.l);
          if (eb.c >= 0) chk("b_out_cyc", cyc, eb.c);
        end
      end
      if (b_tout) b_tout_n++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input logic l, output int ac);
    logic rdy;
    int   n;
    n  = 0;
    ac = -1;
    if (sel) begin b_s_tvalid = 1'b1; b_s_tdata = d; b_s_tlast = l; end
    else     begin a_s_tvalid = 1'b1; a_s_tdata = d; a_s_tlast = l; end
    while (ac < 0 && n < 200) begin
      @(negedge aclk);
      rdy = sel ? b_s_tready : a_s_tready;
      @(posedge aclk); #1;
      if (rdy) ac = cyc;
      n++;
    end
    if (ac < 0) begin
      n_cmp++; n_err++;
      $display("FAIL send_accept: beat %0h got no accept want accept within 200 cycles", d);
    end
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (qa.size() != 0 && n < maxc) begin @(posedge aclk); #1; n++; end
    chk("drain_qa_empty", qa.size(), 0);
    idle(3);
  endtask

  initial begin
    int t0, t1, ac, ac2, ac3;
    int acc[10];

    #2;
    chk("rst_m_tvalid", a_m_tvalid, 0);
    chk("rst_m_tlast", a_m_tlast, 0);
    chk("rst_m_tdata", a_m_tdata, 0);
    chk("rst_tout", a_tout, 0);
    chk("rst_s_tready", a_s_tready, 1);
    @(posedge aclk); #1 aresetn = 1'b1;

    // Reset mid-packet with P and O both full; held beats must vanish.
    a_m_tready = 1'b0;
    send(0, 8'h30, 0, ac);
    send(0, 8'h31, 0, ac);
    a_s_tvalid = 1'b0;
    chk("pre_rst_m_tvalid", a_m_tvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_m_tvalid", a_m_tvalid, 0);
    chk("arst_s_tready", a_s_tready, 1);
    chk("arst_tout", a_tout, 0);
    chk("arst_m_tdata", a_m_tdata, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    a_m_tready = 1'b1;
    send(0, 8'h40, 1, ac);
    push_a(8'h40, 1'b1, ac + 1);
    a_s_tvalid = 1'b0;
    drain(20);

    // Length cap: TLAST on 0x03 and 0x07, 0x09 closed by timeout.
    t0 = a_tout_n;
    for (int k = 0; k < 10; k++) begin
      send(0, 8'(k), 0, acc[k]);
      if (k < 9) push_a(8'(k), (k == 3 || k == 7), acc[k] + 1);
    end
    a_s_tvalid = 1'b0;
    push_a(8'h09, 1'b1, acc[9] + 9);
    drain(40);
    chk("cap_tout_count", a_tout_n - t0, 1);
    chk("cap_tout_cyc", a_tout_cyc, acc[9] + 7);

    // Source TLAST, then the counter restarts from zero.
    t0 = a_tout_n;
    send(0, 8'hA0, 0, ac); push_a(8'hA0, 1'b0, ac + 1);
    send(0, 8'hA1, 1, ac); push_a(8'hA1, 1'b1, ac + 1);
    a_s_tvalid = 1'b0;
    idle(3);
    for (int k = 0; k < 4; k++) begin
      send(0, 8'hB0 + 8'(k), 0, ac);
      push_a(8'hB0 + 8'(k), (k == 3), ac + 1);
    end
    a_s_tvalid = 1'b0;
    drain(40);
    idle(12);
    chk("tlast_no_tout", a_tout_n - t0, 0);

    // Timeout race: accept in the cycle the timer would fire.
    t0 = a_tout_n;
    send(0, 8'h11, 0, t1);
    a_s_tvalid = 1'b0;
    idle(7);
    push_a(8'h11, 1'b0, t1 + 8);
    send(0, 8'h12, 0, ac);
    a_s_tvalid = 1'b0;
    chk("race_acc_cyc", ac, t1 + 8);
    push_a(8'h12, 1'b1, ac + 9);
    drain(40);
    chk("race_tout_count", a_tout_n - t0, 1);
    chk("race_tout_cyc", a_tout_cyc, t1 + 15);

    // Backpressure: 20-cycle stall with 0x22 in O and final 0x23 in P.
    t0 = a_tout_n;
    send(0, 8'h20, 0, ac); push_a(8'h20, 1'b0, ac + 1);
    send(0, 8'h21, 0, ac); push_a(8'h21, 1'b0, ac + 1);
    send(0, 8'h22, 0, ac); push_a(8'h22, 1'b0, ac + 21);
    send(0, 8'h23, 0, t1); push_a(8'h23, 1'b1, t1 + 21);
    a_m_tready = 1'b0;
    fork
      begin
        send(0, 8'h24, 0, ac2);
        push_a(8'h24, 1'b0, ac2 + 1);
        send(0, 8'h25, 0, ac3);
        a_s_tvalid = 1'b0;
        push_a(8'h25, 1'b1, ac3 + 9);
      end
      begin
        repeat (20) @(posedge aclk);
        #1 a_m_tready = 1'b1;
      end
    join
    chk("bp_acc24_cyc", ac2, t1 + 21);
    drain(60);
    chk("bp_tout_count", a_tout_n - t0, 1);
    chk("bp_tout_cyc", a_tout_cyc, ac3 + 7);

    // TIMEOUT=0: a non-final beat is held until its successor arrives.
    send(1, 8'h55, 0, ac);
    b_s_tvalid = 1'b0;
    idle(100);
    chk("t0_held_m_tvalid", b_m_tvalid, 0);
    chk("t0_tout_count", b_tout_n, 0);
    push_b(8'h55, 1'b0, cyc + 1);
    send(1, 8'h56, 0, ac);
    b_s_tvalid = 1'b0;
    idle(5);
    chk("t0_qb_empty", qb.size(), 0);
    chk("t0_56_held", b_m_tvalid, 0);

    chk("end_qa_empty", qa.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_cmp++; n_err++;
    $display("FAIL watchdog: got timeout want bench completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
